// File: rtl/alu_cmd_ctrl.sv
// Byte-command front end for an external ALU: a configure frame loads operands and
// opcode atomically, and a display command transmits the latched result and flags.
module alu_cmd_ctrl #(
  parameter logic [7:0] CMD_CONFIG     = 8'hCD,
  parameter logic [7:0] CMD_DISPLAY    = 8'hD1,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  input  logic       i_tx_done,
  output logic [7:0] o_alu_a,
  output logic [7:0] o_alu_b,
  output logic [5:0] o_alu_op,
  input  logic [7:0] i_alu_result,
  input  logic       i_alu_zero,
  input  logic       i_alu_overflow,
  output logic       o_busy,
  output logic       o_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_OP,
    SEND_RES,
    WAIT_RES,
    SEND_FLG,
    WAIT_FLG
  } state_t;

  state_t           r_state;
  logic [7:0]       r_shadowA;
  logic [7:0]       r_shadowB;
  logic [7:0]       r_resSnap;
  logic [7:0]       r_flgSnap;
  logic [CNT_W-1:0] r_timeoutCnt;

  logic w_opValid;
  logic w_timeoutHit;

  // The whole opcode byte is checked, so set upper bits never alias a legal code.
  always_comb begin
    w_opValid = 1'b0;
    case (i_rx_data)
      8'h20, 8'h22, 8'h24, 8'h25,
      8'h26, 8'h27, 8'h02, 8'h03: w_opValid = 1'b1;
      default:                    w_opValid = 1'b0;
    endcase
  end

  assign w_timeoutHit = (r_timeoutCnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_busy       = (r_state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_shadowA    <= 8'h00;
      r_shadowB    <= 8'h00;
      r_resSnap    <= 8'h00;
      r_flgSnap    <= 8'h00;
      r_timeoutCnt <= '0;
      o_alu_a      <= 8'h00;
      o_alu_b      <= 8'h00;
      o_alu_op     <= 6'h20;
      o_tx_data    <= 8'h00;
      o_tx_start   <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_err      <= 1'b0;
      o_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_CONFIG) begin
              r_state      <= GET_A;
              r_timeoutCnt <= '0;
            end else if (i_rx_data == CMD_DISPLAY) begin
              r_state   <= SEND_RES;
              r_resSnap <= i_alu_result;
              r_flgSnap <= {6'b0, i_alu_overflow, i_alu_zero};
            end else begin
              o_err <= 1'b1;
            end
          end
        end

        // A byte arriving on the final count cycle takes priority over the timeout.
        GET_A, GET_B, GET_OP: begin
          if (i_rx_valid) begin
            r_timeoutCnt <= '0;
            if (r_state == GET_A) begin
              r_shadowA <= i_rx_data;
              r_state   <= GET_B;
            end else if (r_state == GET_B) begin
              r_shadowB <= i_rx_data;
              r_state   <= GET_OP;
            end else begin
              if (w_opValid) begin
                o_alu_a  <= r_shadowA;
                o_alu_b  <= r_shadowB;
                o_alu_op <= i_rx_data[5:0];
              end else begin
                o_err <= 1'b1;
              end
              r_state <= IDLE;
            end
          end else if (w_timeoutHit) begin
            r_state      <= IDLE;
            r_shadowA    <= 8'h00;
            r_shadowB    <= 8'h00;
            r_timeoutCnt <= '0;
            o_err        <= 1'b1;
          end else begin
            r_timeoutCnt <= r_timeoutCnt + CNT_W'(1);
          end
        end

        SEND_RES: begin
          o_tx_data  <= r_resSnap;
          o_tx_start <= 1'b1;
          r_state    <= WAIT_RES;
          if (i_rx_valid) o_err <= 1'b1;
        end

        WAIT_RES: begin
          if (i_tx_done) r_state <= SEND_FLG;
          if (i_rx_valid) o_err <= 1'b1;
        end

        SEND_FLG: begin
          o_tx_data  <= r_flgSnap;
          o_tx_start <= 1'b1;
          r_state    <= WAIT_FLG;
          if (i_rx_valid) o_err <= 1'b1;
        end

        WAIT_FLG: begin
          if (i_tx_done) r_state <= IDLE;
          if (i_rx_valid) o_err <= 1'b1;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: an ALU stub drives the result inputs, and a
// small operand/opcode model predicts commits, errors and transmitted bytes.
module tb_alu_cmd_ctrl;

  localparam int         TB_TIMEOUT = 16;
  localparam logic [7:0] CMD_CFG    = 8'hCD;
  localparam logic [7:0] CMD_DISP   = 8'hD1;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       i_tx_done;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic [7:0] i_alu_result;
  logic       i_alu_zero;
  logic       i_alu_overflow;
  logic       o_busy;
  logic       o_err;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] expA;
  logic [7:0] expB;
  logic [5:0] expOp;

  logic [7:0] validOps [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};

  alu_cmd_ctrl #(
    .CMD_CONFIG    (CMD_CFG),
    .CMD_DISPLAY   (CMD_DISP),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rx_data     (i_rx_data),
    .i_rx_valid    (i_rx_valid),
    .o_tx_data     (o_tx_data),
    .o_tx_start    (o_tx_start),
    .i_tx_done     (i_tx_done),
    .o_alu_a       (o_alu_a),
    .o_alu_b       (o_alu_b),
    .o_alu_op      (o_alu_op),
    .i_alu_result  (i_alu_result),
    .i_alu_zero    (i_alu_zero),
    .i_alu_overflow(i_alu_overflow),
    .o_busy        (o_busy),
    .o_err         (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Returns {overflow, zero, result} for an 8-bit MIPS-style ALU.
  function automatic logic [9:0] aluModel(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
    logic [7:0] r;
    logic       v;
    r = 8'h00;
    v = 1'b0;
    case (op)
      6'h20: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
      6'h22: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h02: r = a >> b[2:0];
      6'h03: r = $unsigned($signed(a) >>> b[2:0]);
      default: r = 8'h00;
    endcase
    return {v, (r == 8'h00), r};
  endfunction

  logic [9:0] aluStub;
  assign aluStub        = aluModel(o_alu_a, o_alu_b, o_alu_op);
  assign i_alu_result   = aluStub[7:0];
  assign i_alu_zero     = aluStub[8];
  assign i_alu_overflow = aluStub[9];

  // Must be called at a negedge; returns at the negedge after the byte was sampled.
  task automatic sendByte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    compared++;
    if ({o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_err, o_busy} !==
        {8'h00, 8'h00, 6'h20, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL %s: got a=%h b=%h op=%h tx=%h st=%b err=%b busy=%b required 00 00 20 00 0 0 0",
               tag, o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_err, o_busy);
    end
  endtask

  task automatic receiveTx(input logic [7:0] expData, input int hold, input bit inject,
                           input string tag);
    int         waited = 0;
    logic [7:0] captured;
    bit         stable = 1'b1;
    bit         restart = 1'b0;
    bit         errSeen = 1'b0;
    while (o_tx_start !== 1'b1 && waited < 20) begin
      @(negedge i_clk);
      waited++;
    end
    compared++;
    if (waited != 1) begin
      mismatched++;
      $display("[TB] FAIL %s latency: got %0d cycles required 1", tag, waited);
    end
    compared++;
    if (o_tx_data !== expData) begin
      mismatched++;
      $display("[TB] FAIL %s data: got %h required %h", tag, o_tx_data, expData);
    end
    captured = o_tx_data;
    for (int i = 0; i < hold; i++) begin
      if (inject && i == 3) begin
        sendByte(8'h55);
        errSeen = o_err;
      end else begin
        @(negedge i_clk);
      end
      if (o_tx_start !== 1'b0) restart = 1'b1;
      if (o_tx_data !== captured) stable = 1'b0;
    end
    if (inject) begin
      compared++;
      if (errSeen !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL %s rx-while-busy err: got %b required 1", tag, errSeen);
      end
    end
    compared++;
    if (restart || !stable) begin
      mismatched++;
      $display("[TB] FAIL %s hold: got restart=%b stable=%b required 0 1", tag, restart, stable);
    end
    i_tx_done = 1'b1;
    @(negedge i_clk);
    i_tx_done = 1'b0;
  endtask

  task automatic doDisplay(input int hold, input bit inject, input string tag);
    logic [9:0] e;
    e = aluModel(expA, expB, expOp);
    sendByte(CMD_DISP);
    compared++;
    if (o_busy !== 1'b1 || o_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s start: got busy=%b err=%b required 1 0", tag, o_busy, o_err);
    end
    receiveTx(e[7:0], hold, inject, {tag, " res"});
    receiveTx({6'b0, e[9], e[8]}, hold, 1'b0, {tag, " flg"});
    compared++;
    if (o_busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s end busy: got %b required 0", tag, o_busy);
    end
  endtask

  task automatic doConfig(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input string tag);
    bit valid;
    valid = op inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
    sendByte(CMD_CFG);
    sendByte(a);
    sendByte(b);
    sendByte(op);
    if (valid) begin
      expA  = a;
      expB  = b;
      expOp = op[5:0];
    end
    compared++;
    if ({o_alu_a, o_alu_b, o_alu_op, o_err, o_busy} !== {expA, expB, expOp, !valid, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL %s config: got a=%h b=%h op=%h err=%b busy=%b required %h %h %h %b 0",
               tag, o_alu_a, o_alu_b, o_alu_op, o_err, o_busy, expA, expB, expOp, !valid);
    end
  endtask

  task automatic test_reset;
    i_rst_n    = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_tx_done  = 1'b0;
    expA  = 8'h00;
    expB  = 8'h00;
    expOp = 6'h20;
    repeat (2) @(negedge i_clk);
    checkResetValues("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    doDisplay(2, 1'b0, "display-before-config");
  endtask

  task automatic test_directed;
    doConfig(8'h05, 8'h0A, 8'h20, "add");
    doDisplay(3, 1'b0, "add-disp");
    doConfig(8'h64, 8'h64, 8'h22, "sub");
    doDisplay(0, 1'b0, "sub-disp");
    doConfig(8'h64, 8'h32, 8'h20, "add-ovf");
    doDisplay(1, 1'b0, "ovf-disp");
    doConfig(8'h11, 8'h22, 8'h3F, "bad-op");
  endtask

  task automatic test_timeout;
    bit errSeen = 1'b0;
    sendByte(CMD_CFG);
    sendByte(8'h05);
    for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
      errSeen |= o_err;
      @(negedge i_clk);
    end
    compared++;
    if (errSeen || o_busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL timeout-early: got err=%b busy=%b required 0 1", errSeen, o_busy);
    end
    @(negedge i_clk);
    compared++;
    if ({o_err, o_busy, o_alu_a, o_alu_b, o_alu_op} !== {1'b1, 1'b0, expA, expB, expOp}) begin
      mismatched++;
      $display("[TB] FAIL timeout: got err=%b busy=%b a=%h required 1 0 %h", o_err, o_busy,
               o_alu_a, expA);
    end
    sendByte(CMD_CFG);
    sendByte(8'h05);
    repeat (TB_TIMEOUT - 1) @(negedge i_clk);
    sendByte(8'h0A);
    compared++;
    if (o_err !== 1'b0 || o_busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL last-count-byte: got err=%b busy=%b required 0 1", o_err, o_busy);
    end
    sendByte(8'h26);
    expA  = 8'h05;
    expB  = 8'h0A;
    expOp = 6'h26;
    compared++;
    if ({o_alu_a, o_alu_b, o_alu_op, o_err} !== {expA, expB, expOp, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL last-count-commit: got %h %h %h err=%b required %h %h %h 0",
               o_alu_a, o_alu_b, o_alu_op, o_err, expA, expB, expOp);
    end
  endtask

  task automatic test_back_to_back;
    bit spurious = 1'b0;
    doDisplay(50, 1'b1, "rx-during-wait");
    doDisplay(0, 1'b0, "back-to-back");
    i_tx_done = 1'b1;
    @(negedge i_clk);
    i_tx_done = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      if (o_tx_start !== 1'b0 || o_busy !== 1'b0) spurious = 1'b1;
    end
    compared++;
    if (spurious) begin
      mismatched++;
      $display("[TB] FAIL idle-tx-done: got activity=1 required 0");
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b, op, junk;
    for (int n = 0; n < 24; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        do op = 8'($urandom); while (op inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03});
      end else begin
        op = validOps[$urandom_range(0, 7)];
      end
      doConfig(a, b, op, "rand-config");
      if (n % 3 == 0) doDisplay($urandom_range(0, 5), 1'b0, "rand-disp");
      if (n % 5 == 0) begin
        do junk = 8'($urandom); while (junk == CMD_CFG || junk == CMD_DISP);
        sendByte(junk);
        compared++;
        if (o_err !== 1'b1 || o_busy !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL idle-junk %h: got err=%b busy=%b required 1 0", junk, o_err, o_busy);
        end
      end
    end
  endtask

  task automatic test_reset_midway;
    bit spurious = 1'b0;
    logic [9:0] e;
    sendByte(CMD_CFG);
    sendByte(8'h33);
    #3 i_rst_n = 1'b0;
    expA  = 8'h00;
    expB  = 8'h00;
    expOp = 6'h20;
    #1 checkResetValues("reset-in-getb");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    sendByte(8'h44);
    compared++;
    if (o_err !== 1'b1 || o_busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL frame-abandoned: got err=%b busy=%b required 1 0", o_err, o_busy);
    end
    doConfig(8'h0F, 8'hF0, 8'h25, "pre-reset-config");
    e = aluModel(expA, expB, expOp);
    sendByte(CMD_DISP);
    receiveTx(e[7:0], 1, 1'b0, "pre-reset res");
    repeat (3) @(negedge i_clk);
    #3 i_rst_n = 1'b0;
    expA  = 8'h00;
    expB  = 8'h00;
    expOp = 6'h20;
    #1 checkResetValues("reset-in-waitflg");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (10) begin
      @(negedge i_clk);
      if (o_tx_start !== 1'b0 || o_busy !== 1'b0) spurious = 1'b1;
    end
    compared++;
    if (spurious) begin
      mismatched++;
      $display("[TB] FAIL post-reset-quiet: got activity=1 required 0");
    end
    doDisplay(2, 1'b0, "post-reset-disp");
  endtask

  initial begin
    $display("[TB] starting alu_cmd_ctrl bench");
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 SHALL have parameter CMD_CONFIG, default 8'hCD, configure-command byte.
REQ-002 SHALL have parameter CMD_DISPLAY, default 8'hD1, display-command byte.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, max clocks between bytes of one configure frame.
REQ-004 SHALL have ports: i_clk  in  1  sole clock; i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: i_rx_data  in  8  received byte; i_rx_valid  in  1  one-cycle pulse, i_rx_data valid.
REQ-006 SHALL have ports: o_tx_data  out  8  byte to send; o_tx_start  out  1  one-cycle send request; i_tx_done  in  1  one-cycle pulse, byte fully sent incl. stop bit.
REQ-007 SHALL have ports: o_alu_a  out  8  operand A; o_alu_b  out  8  operand B; o_alu_op  out  6  opcode (byte[5:0]).
REQ-008 SHALL have ports: i_alu_result  in  8; i_alu_zero  in  1; i_alu_overflow  in  1.
REQ-009 SHALL have ports: o_busy  out  1  high in any state except IDLE; o_err  out  1  one-cycle protocol-error pulse.

Function
REQ-010 SHALL implement states IDLE, GET_A, GET_B, GET_OP, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
REQ-011 IDLE: rx byte == CMD_CONFIG -> GET_A; == CMD_DISPLAY -> SEND_RES; other byte -> stay IDLE, pulse o_err.
REQ-012 GET_A/GET_B: rx byte stored in shadow A/B; advance to GET_B/GET_OP.
REQ-013 GET_OP: valid opcodes 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x02 SRL, 0x03 SRA.
REQ-014 GET_OP valid opcode: shadow A, shadow B, opcode committed to o_alu_a/b/op together on clock after rx pulse; -> IDLE.
REQ-015 GET_OP invalid opcode: no commit, outputs keep prior values, o_err pulse, -> IDLE.
REQ-016 o_alu_a/b/op SHALL change only on a valid commit or reset; never partially updated.
REQ-017 Timeout counter cleared on entry to GET_A and on every rx pulse in GET_A/GET_B/GET_OP; increments each other cycle there.
REQ-018 Counter reaching TIMEOUT_CYCLES-1: -> IDLE, shadows discarded, o_err pulse; rx pulse same cycle wins (byte accepted, no timeout).
REQ-019 Entry to SEND_RES: snapshot i_alu_result and {6'b0, i_alu_overflow, i_alu_zero} into result/flag registers on clock after D1 rx pulse.
REQ-020 SEND_RES: o_tx_data = result snapshot, o_tx_start high exactly one cycle, -> WAIT_RES.
REQ-021 WAIT_RES: hold until i_tx_done, -> SEND_FLG; SEND_FLG sends flag snapshot same way, -> WAIT_FLG; i_tx_done -> IDLE.
REQ-022 o_tx_data SHALL stay stable from o_tx_start until matching i_tx_done.
REQ-023 Latency: D1 rx pulse at cycle N -> o_tx_start at cycle N+2; i_tx_done at M -> next o_tx_start at M+2.
REQ-024 rx pulses during SEND_*/WAIT_*: byte dropped, o_err pulse, sequence unaffected.
REQ-025 i_tx_done outside WAIT_RES/WAIT_FLG SHALL be ignored.
REQ-026 Display before any configure SHALL report ALU output for reset operands (A=0,B=0,ADD): 0x00 then 0x01.

Reset
REQ-027 i_rst_n low SHALL immediately force IDLE, o_alu_a=0, o_alu_b=0, o_alu_op=6'h20, o_tx_data=0, o_tx_start=0, o_err=0, o_busy=0, shadows/snapshots/counter=0.
REQ-028 Reset mid-frame or mid-transmission SHALL abandon the operation; no further o_tx_start until a new D1.

Verification
REQ-029 CD,05,0A,20 then D1 (ALU model: 15, Z0, V0) -> o_alu_a=05,b=0A,op=20 after OP byte; tx 0x0F then 0x00.
REQ-030 CD,64,64,22 then D1 -> tx 0x00 then 0x01; CD,64,32,20 then D1 -> tx 0x96 then 0x02.
REQ-031 CD,11,22,3F -> o_err pulse, o_alu_a/b/op unchanged from prior values, o_busy low after.
REQ-032 CD,05 then silence TIMEOUT_CYCLES clocks -> o_err pulse, IDLE; byte arriving on final count cycle accepted, no error.
REQ-033 D1 then byte 0x55 during WAIT_RES -> o_err pulse, both bytes still sent; i_tx_done held off 50 cycles -> o_tx_start not reasserted early.
REQ-034 i_rst_n low during GET_B and during WAIT_FLG -> outputs at REQ-027 values asynchronously; subsequent D1 -> 0x00, 0x01.
